// File: rtl/gate_truth_sweeper_pkg.sv
// Shared types and sizing helpers for the gate truth-table sweeper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned nvec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // err_count must reach NVEC itself, hence one bit wider than the vector index
  function automatic int unsigned err_width(input int unsigned n_in);
    return n_in + 32'd1;
  endfunction

endpackage

// File: rtl/gate_truth_sweeper_if.sv
// Control, status and gate-drive signals between the sweeper and its host/gate.
interface gate_truth_sweeper_if
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 2
);
  localparam int unsigned NVEC = nvec(N_IN);
  localparam int unsigned EW   = err_width(N_IN);

  logic            start;
  logic [NVEC-1:0] expect_tt;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [EW-1:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    output start, expect_tt, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, expect_tt, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_truth_sweeper_settle_counter.sv
// Holds each vector for SETTLE cycles; expire is high on the last WAIT cycle.
module settle_counter
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);
endmodule

// File: rtl/gate_truth_sweeper.sv
// Sweeps all input vectors into a gate under test and checks against a latched truth table.
module gate_truth_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_truth_sweeper_if.slave bus
);
  localparam int unsigned NVEC = nvec(N_IN);
  localparam int unsigned EW   = err_width(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t          state, state_nxt;
  logic [N_IN-1:0] vec;
  logic [NVEC-1:0] tt_q;
  logic [EW-1:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;
  logic            pass;
  logic            expire;
  logic            settle_load;
  logic            mismatch;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (settle_load),
    .en     (state == WAIT),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = WAIT;
      WAIT:    if (expire) state_nxt = CHECK;
      CHECK:   state_nxt = (vec == LAST_VEC) ? DONE : WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign settle_load = (state != WAIT) && (state_nxt == WAIT);
  assign mismatch    = (state == CHECK) && (bus.dut_out != tt_q[vec]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      tt_q             <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tt_q             <= bus.expect_tt;
            vec              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          // pass is settled here so it is already valid during the DONE pulse
          if (vec == LAST_VEC) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec <= vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in           = vec;
  assign bus.busy             = (state == WAIT) || (state == CHECK);
  assign bus.done             = (state == DONE);
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail_vec   = first_fail_vec;
  assign bus.first_fail_valid = first_fail_valid;
endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Directed bench: sweeper driving a behavioural 2-input NAND.
module tb_gate_truth_sweeper;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  gate_truth_sweeper_if #(.N_IN(2)) bus ();

  gate_truth_sweeper #(.N_IN(2), .SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.dut_out = ~&bus.dut_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with tt and runs until done (bounded); optional mid-sweep disturbance.
  task automatic do_sweep(input logic [3:0] tt, input bit disturb, output int cycles);
    bus.expect_tt = tt;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    cycles    = 1;
    while (!bus.done && cycles < 40) begin
      if (disturb && cycles == 5) begin
        bus.start     = 1'b1;
        bus.expect_tt = 4'b0111;
      end else begin
        bus.start = 1'b0;
      end
      step();
      cycles++;
    end
    bus.start = 1'b0;
    n_assert++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL sweep_timeout: done=%0b after %0d cycles, required done=1", bus.done, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_assert++;
    if ({bus.busy, bus.done, bus.pass, bus.first_fail_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/pass/ffv=%b required 0000",
               {bus.busy, bus.done, bus.pass, bus.first_fail_valid});
    end
    n_assert++;
    if (bus.err_count !== 3'd0 || bus.dut_in !== 2'b00 || bus.first_fail_vec !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: err=%0d dut_in=%b ffvec=%b required 0 00 00",
               bus.err_count, bus.dut_in, bus.first_fail_vec);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nand_pass();
    logic [1:0] exp_in;
    bus.expect_tt = 4'b0111;
    bus.start     = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step();
      bus.start = 1'b0;
      if (n <= 12) begin
        exp_in = 2'((n - 1) / 3);
        n_assert++;
        if (bus.dut_in !== exp_in || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_cycle%0d: dut_in=%b busy=%b done=%b required %b 1 0",
                   n, bus.dut_in, bus.busy, bus.done, exp_in);
        end
      end else begin
        n_assert++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.dut_in !== 2'b11) begin
          n_fail++;
          $display("FAIL pass_done13: done=%b busy=%b dut_in=%b required 1 0 11",
                   bus.done, bus.busy, bus.dut_in);
        end
        n_assert++;
        if (bus.pass !== 1'b1 || bus.err_count !== 3'd0 || bus.first_fail_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_result: pass=%b err=%0d ffv=%b required 1 0 0",
                   bus.pass, bus.err_count, bus.first_fail_valid);
        end
      end
    end
    step();
    n_assert++;
    if (bus.done !== 1'b0 || bus.pass !== 1'b1 || bus.dut_in !== 2'b11) begin
      n_fail++;
      $display("FAIL pass_hold: done=%b pass=%b dut_in=%b required 0 1 11",
               bus.done, bus.pass, bus.dut_in);
    end
  endtask

  task automatic test_and_table();
    int cycles;
    do_sweep(4'b1000, 1'b0, cycles);
    n_assert++;
    if (cycles !== 13) begin
      n_fail++;
      $display("FAIL and_latency: %0d cycles required 13", cycles);
    end
    n_assert++;
    if (bus.err_count !== 3'd4 || bus.first_fail_vec !== 2'b00 ||
        bus.first_fail_valid !== 1'b1 || bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL and_result: err=%0d ffvec=%b ffv=%b pass=%b required 4 00 1 0",
               bus.err_count, bus.first_fail_vec, bus.first_fail_valid, bus.pass);
    end
    step();
  endtask

  task automatic test_all_ones();
    int cycles;
    do_sweep(4'b1111, 1'b0, cycles);
    n_assert++;
    if (bus.err_count !== 3'd1 || bus.first_fail_vec !== 2'b11 ||
        bus.first_fail_valid !== 1'b1 || bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_result: err=%0d ffvec=%b ffv=%b pass=%b required 1 11 1 0",
               bus.err_count, bus.first_fail_vec, bus.first_fail_valid, bus.pass);
    end
    step();
  endtask

  task automatic test_ignore_midsweep();
    int cycles;
    do_sweep(4'b1111, 1'b1, cycles);
    n_assert++;
    if (cycles !== 13) begin
      n_fail++;
      $display("FAIL ignore_latency: %0d cycles required 13", cycles);
    end
    n_assert++;
    if (bus.err_count !== 3'd1 || bus.first_fail_vec !== 2'b11 || bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: err=%0d ffvec=%b pass=%b required 1 11 0",
               bus.err_count, bus.first_fail_vec, bus.pass);
    end
    step();
    n_assert++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_count !== 3'd1) begin
      n_fail++;
      $display("FAIL ignore_idle: busy=%b done=%b err=%0d required 0 0 1",
               bus.busy, bus.done, bus.err_count);
    end
  endtask

  task automatic test_reset_midsweep();
    int cycles;
    bus.expect_tt = 4'b1000;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 20 && bus.dut_in !== 2'b10; n++) step();
    n_assert++;
    if (bus.dut_in !== 2'b10 || bus.err_count !== 3'd2) begin
      n_fail++;
      $display("FAIL midreset_reach: dut_in=%b err=%0d required 10 2", bus.dut_in, bus.err_count);
    end
    rst_n = 1'b0;
    step();
    n_assert++;
    if (bus.dut_in !== 2'b00 || bus.busy !== 1'b0 || bus.err_count !== 3'd0 ||
        bus.first_fail_valid !== 1'b0 || bus.pass !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_vals: dut_in=%b busy=%b err=%0d ffv=%b pass=%b done=%b required 00 0 0 0 0 0",
               bus.dut_in, bus.busy, bus.err_count, bus.first_fail_valid, bus.pass, bus.done);
    end
    rst_n = 1'b1;
    step();
    do_sweep(4'b0111, 1'b0, cycles);
    n_assert++;
    if (cycles !== 13 || bus.pass !== 1'b1 || bus.err_count !== 3'd0 ||
        bus.first_fail_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_resweep: cycles=%0d pass=%b err=%0d ffv=%b required 13 1 0 0",
               cycles, bus.pass, bus.err_count, bus.first_fail_valid);
    end
    step();
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.expect_tt = 4'b0000;
    test_reset();
    test_nand_pass();
    test_and_table();
    test_all_ones();
    test_ignore_midsweep();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
